// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the FIFO controller: default parameters and the status-flag bundle.
// Widths are still derived locally from ADDR_WIDTH in each module.
package fifo_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned DEF_AF_LEVEL   = 6;
    localparam int unsigned DEF_AE_LEVEL   = 2;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    localparam fifo_status_t STATUS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    // Status is always computed from the occupancy the FIFO will have after this edge.
    function automatic fifo_status_t calc_status(
        input int unsigned cnt,
        input int unsigned depth,
        input int unsigned af_level,
        input int unsigned ae_level
    );
        fifo_status_t s;
        s.full         = (cnt == depth);
        s.empty        = (cnt == 0);
        s.almost_full  = (cnt >= af_level);
        s.almost_empty = (cnt <= ae_level);
        return s;
    endfunction

endpackage

// File: rtl/ptr_counter.sv
// Wrapping pointer for one side of the FIFO; DEPTH is a power of two, so the natural
// rollover of a WIDTH-bit register gives the DEPTH-1 -> 0 wrap.
module ptr_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_d;
    logic [WIDTH-1:0] ptr_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller: accepts push/pop requests, drives register-file
// addresses and write strobe, and keeps registered occupancy and status flags.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = DEF_AF_LEVEL,
    parameter int unsigned AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic         rd_ok;
    logic         wr_ok;
    logic         wr_acc;
    logic         rd_acc;

    logic [ADDR_WIDTH:0] count_d;
    logic [ADDR_WIDTH:0] count_q;
    fifo_status_t        status_d;
    fifo_status_t        status_q;
    logic                overflow_d;
    logic                overflow_q;
    logic                underflow_d;
    logic                underflow_q;

    // A full FIFO can still take a push when a pop frees a slot in the same cycle.
    assign rd_ok  = rd && !status_q.empty;
    assign wr_ok  = wr && (!status_q.full || rd_ok);
    assign wr_acc = wr_ok && !clear;
    assign rd_acc = rd_ok && !clear;

    // Gated by reset_n so the register file never sees a write while reset is held.
    assign wr_en = wr_acc && reset_n;

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok && !rd_ok) begin
                count_d = count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - 1'b1;
            end
            if (wr && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (rd && !rd_ok) begin
                underflow_d = 1'b1;
            end
        end
        status_d = calc_status(32'(count_d), DEPTH, AF_LEVEL, AE_LEVEL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            status_q    <= STATUS_RESET;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            status_q    <= status_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    ptr_counter #(
        .WIDTH (ADDR_WIDTH)
    ) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (wr_acc),
        .ptr     (wr_addr)
    );

    ptr_counter #(
        .WIDTH (ADDR_WIDTH)
    ) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (rd_acc),
        .ptr     (rd_addr)
    );

    assign count        = count_q;
    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2.
module tb_fifo_ctrl;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          wr;
    logic          rd;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .wr           (wr),
        .rd           (rd),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input int cnt, input int f, input int e,
                                input int af, input int ae);
        check({tag, ".count"},        32'(count),        32'(cnt));
        check({tag, ".full"},         32'(full),         32'(f));
        check({tag, ".empty"},        32'(empty),        32'(e));
        check({tag, ".almost_full"},  32'(almost_full),  32'(af));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;

        // Reset state, sampled between edges.
        #12;
        check_status("reset", 0, 0, 1, 0, 1);
        check("reset.wr_addr",   32'(wr_addr),   32'd0);
        check("reset.rd_addr",   32'(rd_addr),   32'd0);
        check("reset.overflow",  32'(overflow),  32'd0);
        check("reset.underflow", 32'(underflow), 32'd0);
        wr = 1'b1;
        #1;
        check("reset.wr_en_held", 32'(wr_en), 32'd0);
        wr = 1'b0;
        reset_n = 1'b1;
        tick();

        // Eight pushes fill the FIFO; almost_full from the sixth.
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1;
            #1;
            check("push.wr_en",   32'(wr_en),   32'd1);
            check("push.wr_addr", 32'(wr_addr), 32'(i));
            tick();
            check_status("push", i + 1, (i == 7) ? 1 : 0, 0, (i >= 5) ? 1 : 0, (i <= 1) ? 1 : 0);
        end
        wr = 1'b0;
        check("fill.wr_addr_wrap", 32'(wr_addr), 32'd0);

        // Push into a full FIFO is refused and flagged.
        wr = 1'b1;
        #1;
        check("ovf.wr_en", 32'(wr_en), 32'd0);
        tick();
        wr = 1'b0;
        check_status("ovf", 8, 1, 0, 1, 0);
        check("ovf.overflow",  32'(overflow), 32'd1);
        check("ovf.wr_addr",   32'(wr_addr),  32'd0);

        // Simultaneous push and pop while full: both accepted, count unchanged.
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1;
            rd = 1'b1;
            #1;
            check("full_rw.wr_en", 32'(wr_en), 32'd1);
            tick();
            check_status("full_rw", 8, 1, 0, 1, 0);
        end
        wr = 1'b0;
        rd = 1'b0;
        check("full_rw.wr_addr", 32'(wr_addr), 32'd3);
        check("full_rw.rd_addr", 32'(rd_addr), 32'd3);

        // Eight pops drain it; rd_addr starts at 3 and wraps.
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1;
            #1;
            check("pop.rd_addr", 32'(rd_addr), 32'((i + 3) % 8));
            check("pop.wr_en",   32'(wr_en),   32'd0);
            tick();
            check_status("pop", 7 - i, 0, (i == 7) ? 1 : 0, (7 - i >= 6) ? 1 : 0, (7 - i <= 2) ? 1 : 0);
        end
        rd = 1'b0;
        check("drain.rd_addr",   32'(rd_addr),   32'd3);
        check("drain.underflow", 32'(underflow), 32'd0);

        // Empty with push and pop together: only the push is taken.
        wr = 1'b1;
        rd = 1'b1;
        #1;
        check("empty_rw.wr_en", 32'(wr_en), 32'd1);
        tick();
        wr = 1'b0;
        rd = 1'b0;
        check_status("empty_rw", 1, 0, 0, 0, 1);
        check("empty_rw.rd_addr",   32'(rd_addr),   32'd3);
        check("empty_rw.wr_addr",   32'(wr_addr),   32'd4);
        check("empty_rw.underflow", 32'(underflow), 32'd1);

        // Bring occupancy to 5; overflow stays sticky.
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1;
            tick();
        end
        wr = 1'b0;
        check_status("fill5", 5, 0, 0, 0, 0);
        check("fill5.wr_addr",  32'(wr_addr),  32'd0);
        check("fill5.overflow", 32'(overflow), 32'd1);

        // Clear beats a concurrent push.
        clear = 1'b1;
        wr    = 1'b1;
        #1;
        check("clear.wr_en", 32'(wr_en), 32'd0);
        tick();
        clear = 1'b0;
        wr    = 1'b0;
        check_status("clear", 0, 0, 1, 0, 1);
        check("clear.wr_addr",   32'(wr_addr),   32'd0);
        check("clear.rd_addr",   32'(rd_addr),   32'd0);
        check("clear.overflow",  32'(overflow),  32'd0);
        check("clear.underflow", 32'(underflow), 32'd0);

        // Occupancy 4, then an asynchronous reset pulse between edges.
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1;
            tick();
        end
        wr = 1'b0;
        check_status("fill4", 4, 0, 0, 0, 0);
        check("fill4.wr_addr", 32'(wr_addr), 32'd4);
        reset_n = 1'b0;
        #1;
        check_status("async_rst", 0, 0, 1, 0, 1);
        check("async_rst.wr_addr", 32'(wr_addr), 32'd0);
        check("async_rst.rd_addr", 32'(rd_addr), 32'd0);
        #1;
        reset_n = 1'b1;
        wr = 1'b1;
        #1;
        check("post_rst.wr_en",   32'(wr_en),   32'd1);
        check("post_rst.wr_addr", 32'(wr_addr), 32'd0);
        tick();
        wr = 1'b0;
        check_status("post_rst", 1, 0, 0, 0, 1);
        check("post_rst.wr_addr_next", 32'(wr_addr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
